stream_upsizer: RTL

Valid/ready stream width converter that packs `RATIO` consecutive `DATA_WIDTH`-bit beats into one `DATA_WIDTH*RATIO`-bit word, with an early flush on `last`. It sits directly upstream of the buffering stage of the streaming datapath and feeds that stage's valid/ready input. Its output is a single registered stage, so the following block sees registered data, keep, last and valid.

---
 rtl/stream_upsizer.sv | 104 ++++++++++
 1 files changed

// File: rtl/stream_upsizer.sv
// Valid/ready width converter: packs RATIO narrow beats into one wide word,
// flushing early on last. Output word, keep, last and valid are registered.
module stream_upsizer #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned RATIO      = 4
) (
  input  logic                        clk_i,
  input  logic                        arst_ni,
  input  logic [DATA_WIDTH-1:0]       data_in_i,
  input  logic                        data_in_last_i,
  input  logic                        data_in_valid_i,
  output logic                        data_in_ready_o,
  output logic [DATA_WIDTH*RATIO-1:0] data_out_o,
  output logic [RATIO-1:0]            data_out_keep_o,
  output logic                        data_out_last_o,
  output logic                        data_out_valid_o,
  input  logic                        data_out_ready_i
);

  localparam int unsigned CNT_W = $clog2(RATIO);
  localparam int unsigned OUT_W = DATA_WIDTH * RATIO;

  logic [RATIO-2:0][DATA_WIDTH-1:0] r_acc;
  logic [CNT_W-1:0]                 r_cnt;
  logic [OUT_W-1:0]                 r_data;
  logic [RATIO-1:0]                 r_keep;
  logic                             r_last;
  logic                             r_valid;

  logic                             w_in_fire;
  logic                             w_out_fire;
  logic                             w_cnt_full;
  logic                             w_complete;
  logic [OUT_W-1:0]                 w_word;
  logic [RATIO-1:0]                 w_keep;

  // Ready only depends on the output slot being free or draining this cycle.
  assign data_in_ready_o = !r_valid || data_out_ready_i;

  assign w_in_fire  = data_in_valid_i && data_in_ready_o;
  assign w_out_fire = r_valid && data_out_ready_i;
  assign w_cnt_full = (r_cnt == CNT_W'(RATIO - 1));
  assign w_complete = w_in_fire && (w_cnt_full || data_in_last_i);

  // Assemble the outgoing word: filled lanes, current beat at lane cnt, zeros above.
  always_comb begin
    w_word = '0;
    w_keep = '0;
    for (int unsigned k = 0; k < RATIO - 1; k++) begin
      if (CNT_W'(k) < r_cnt) begin
        w_word[k*DATA_WIDTH +: DATA_WIDTH] = r_acc[k];
        w_keep[k]                          = 1'b1;
      end
    end
    for (int unsigned k = 0; k < RATIO; k++) begin
      if (CNT_W'(k) == r_cnt) begin
        w_word[k*DATA_WIDTH +: DATA_WIDTH] = data_in_i;
        w_keep[k]                          = 1'b1;
      end
    end
  end

  // Partial accumulator and lane counter.
  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      r_acc <= '0;
      r_cnt <= '0;
    end else if (w_in_fire) begin
      if (w_complete) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
        for (int unsigned k = 0; k < RATIO - 1; k++) begin
          if (CNT_W'(k) == r_cnt) begin
            r_acc[k] <= data_in_i;
          end
        end
      end
    end
  end

  // Single output stage; a completing beat may reload it in the cycle it drains.
  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      r_data  <= '0;
      r_keep  <= '0;
      r_last  <= 1'b0;
      r_valid <= 1'b0;
    end else if (w_complete) begin
      r_data  <= w_word;
      r_keep  <= w_keep;
      r_last  <= data_in_last_i;
      r_valid <= 1'b1;
    end else if (w_out_fire) begin
      r_valid <= 1'b0;
    end
  end

  assign data_out_o       = r_data;
  assign data_out_keep_o  = r_keep;
  assign data_out_last_o  = r_last;
  assign data_out_valid_o = r_valid;

endmodule
